// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the write-back arbiter and its holding slots.
package wb_arbiter_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned TAG_W   = 3;
    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned RR_W    = 2;

    typedef logic [XLEN-1:0]    word_t;
    typedef logic [RADDR_W-1:0] regaddr_t;
    typedef logic [TAG_W-1:0]   regtag_t;

    localparam regtag_t UNLOCKED   = TAG_W'(0);
    localparam regtag_t ALU_MASTER = TAG_W'(1);
    localparam regtag_t LOAD_STORE = TAG_W'(2);

    localparam int unsigned WB_ALU0 = 0;
    localparam int unsigned WB_ALU1 = 1;
    localparam int unsigned WB_LS   = 2;

    typedef struct packed {
        regaddr_t addr;
        word_t    data;
        regtag_t  tag;
    } wb_req_t;

    // Requester index p+k, wrapped into 0..NUM_REQ-1.
    function automatic logic [RR_W-1:0] rr_add(input logic [RR_W-1:0] p, input int unsigned k);
        logic [RR_W:0] s;
        s = (RR_W+1)'(p) + (RR_W+1)'(k);
        if (s >= (RR_W+1)'(NUM_REQ)) begin
            s = s - (RR_W+1)'(NUM_REQ);
        end
        return RR_W'(s);
    endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry result holding register; flush beats load, load beats drain.
module wb_slot
    import wb_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load_i,
    input  logic    drain_i,
    input  logic    flush_i,
    input  wb_req_t req_i,
    output logic    valid_o,
    output wb_req_t req_o
);

    logic    valid_q, valid_d;
    wb_req_t req_q, req_d;

    always_comb begin
        valid_d = valid_q;
        req_d   = req_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            req_d   = req_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            req_q   <= '0;
        end else begin
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

    assign valid_o = valid_q;
    assign req_o   = req_q;

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter: three holding slots drained onto two register-file write ports.
module wb_arbiter
    import wb_arbiter_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rdy_i,
    input  logic                              flush_i,
    input  logic [NUM_REQ-1:0]                in_valid_i,
    output logic [NUM_REQ-1:0]                in_ready_o,
    input  logic [NUM_REQ-1:0][RADDR_W-1:0]   in_addr_i,
    input  logic [NUM_REQ-1:0][XLEN-1:0]      in_data_i,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]     in_tag_i,
    output logic                              wr_en0_o,
    output logic [RADDR_W-1:0]                wr_addr0_o,
    output logic [XLEN-1:0]                   wr_data0_o,
    output logic [TAG_W-1:0]                  wr_tag0_o,
    output logic                              wr_en1_o,
    output logic [RADDR_W-1:0]                wr_addr1_o,
    output logic [XLEN-1:0]                   wr_data1_o,
    output logic [TAG_W-1:0]                  wr_tag1_o
);

    logic [NUM_REQ-1:0] slot_valid;
    wb_req_t            slot_req [NUM_REQ];
    wb_req_t            in_req   [NUM_REQ];
    logic [NUM_REQ-1:0] drain, drain_fire, load;
    logic               fire, flush_fire;

    logic [RR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [RR_W-1:0]    scan_idx, p0_idx, p1_idx;
    logic               p0_vld, p1_vld;
    regaddr_t           p0_addr;

    assign fire       = rdy_i && !flush_i;
    assign flush_fire = rdy_i && flush_i;
    assign in_ready_o = {NUM_REQ{fire}} & (~slot_valid | drain);
    assign load       = in_valid_i & in_ready_o;
    assign drain_fire = drain & {NUM_REQ{fire}};

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            in_req[i] = '{addr: in_addr_i[i], data: in_data_i[i], tag: in_tag_i[i]};
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
        wb_slot u_slot (
            .clk     (clk),
            .rst     (rst),
            .load_i  (load[g]),
            .drain_i (drain_fire[g]),
            .flush_i (flush_fire),
            .req_i   (in_req[g]),
            .valid_o (slot_valid[g]),
            .req_o   (slot_req[g])
        );
    end

    // Grant scan from rr_ptr; x0 slots drain without a port, same-address collisions wait.
    always_comb begin
        drain    = '0;
        p0_vld   = 1'b0;
        p1_vld   = 1'b0;
        p0_idx   = '0;
        p1_idx   = '0;
        p0_addr  = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = rr_add(rr_ptr_q, k);
            if (slot_valid[scan_idx]) begin
                if (slot_req[scan_idx].addr == '0) begin
                    drain[scan_idx] = 1'b1;
                end else if (!p0_vld) begin
                    p0_vld          = 1'b1;
                    p0_idx          = scan_idx;
                    p0_addr         = slot_req[scan_idx].addr;
                    drain[scan_idx] = 1'b1;
                end else if (!p1_vld && (slot_req[scan_idx].addr != p0_addr)) begin
                    p1_vld          = 1'b1;
                    p1_idx          = scan_idx;
                    drain[scan_idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        wr_en0_o   = p0_vld && fire;
        wr_addr0_o = wr_en0_o ? slot_req[p0_idx].addr : '0;
        wr_data0_o = wr_en0_o ? slot_req[p0_idx].data : '0;
        wr_tag0_o  = wr_en0_o ? slot_req[p0_idx].tag  : '0;
        wr_en1_o   = p1_vld && fire;
        wr_addr1_o = wr_en1_o ? slot_req[p1_idx].addr : '0;
        wr_data1_o = wr_en1_o ? slot_req[p1_idx].data : '0;
        wr_tag1_o  = wr_en1_o ? slot_req[p1_idx].tag  : '0;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (fire && p0_vld) begin
            rr_ptr_d = rr_add(p1_vld ? p1_idx : p0_idx, 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: arbitration order, collisions, x0, stall, flush, async reset.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    logic                            clk = 1'b0;
    logic                            rst;
    logic                            rdy;
    logic                            flush;
    logic [NUM_REQ-1:0]              in_valid;
    logic [NUM_REQ-1:0]              in_ready;
    logic [NUM_REQ-1:0][RADDR_W-1:0] in_addr;
    logic [NUM_REQ-1:0][XLEN-1:0]    in_data;
    logic [NUM_REQ-1:0][TAG_W-1:0]   in_tag;
    logic                            wr_en0, wr_en1;
    logic [RADDR_W-1:0]              wr_addr0, wr_addr1;
    logic [XLEN-1:0]                 wr_data0, wr_data1;
    logic [TAG_W-1:0]                wr_tag0, wr_tag1;

    int n_tests = 0;
    int n_fail  = 0;

    wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .rdy_i      (rdy),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_addr_i  (in_addr),
        .in_data_i  (in_data),
        .in_tag_i   (in_tag),
        .wr_en0_o   (wr_en0),
        .wr_addr0_o (wr_addr0),
        .wr_data0_o (wr_data0),
        .wr_tag0_o  (wr_tag0),
        .wr_en1_o   (wr_en1),
        .wr_addr1_o (wr_addr1),
        .wr_data1_o (wr_data1),
        .wr_tag1_o  (wr_tag1)
    );

    always #5 clk = ~clk;

    task automatic idle();
        in_valid = '0;
        in_addr  = '0;
        in_data  = '0;
        in_tag   = '0;
    endtask

    task automatic offer(input int i, input logic [RADDR_W-1:0] a, input logic [XLEN-1:0] d,
                         input logic [TAG_W-1:0] t);
        in_valid[i] = 1'b1;
        in_addr[i]  = a;
        in_data[i]  = d;
        in_tag[i]   = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rdy   = 1'b1;
        flush = 1'b0;
        rst   = 1'b1;
        #2;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rdy = 1'b1; flush = 1'b0; rst = 1'b1;
        #12;
        n_tests++; if ({wr_en0, wr_addr0, wr_data0, wr_tag0} !== '0) begin n_fail++; $display("FAIL reset_port0 got %h exp 0", {wr_en0, wr_addr0, wr_data0, wr_tag0}); end
        n_tests++; if ({wr_en1, wr_addr1, wr_data1, wr_tag1} !== '0) begin n_fail++; $display("FAIL reset_port1 got %h exp 0", {wr_en1, wr_addr1, wr_data1, wr_tag1}); end
        n_tests++; if (in_ready !== 3'b111) begin n_fail++; $display("FAIL reset_ready got %b exp 111", in_ready); end
        n_tests++; if (dut.rr_ptr_q !== 2'd0) begin n_fail++; $display("FAIL reset_rr got %0d exp 0", dut.rr_ptr_q); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        offer(WB_ALU0, 5'd5, 32'h11, ALU_MASTER);
        tick(); idle(); #1;
        n_tests++; if ({wr_en0, wr_addr0, wr_data0, wr_tag0} !== {1'b1, 5'd5, 32'h11, 3'd1}) begin n_fail++; $display("FAIL single_port0 got %h exp %h", {wr_en0, wr_addr0, wr_data0, wr_tag0}, {1'b1, 5'd5, 32'h11, 3'd1}); end
        n_tests++; if (wr_en1 !== 1'b0) begin n_fail++; $display("FAIL single_en1 got %b exp 0", wr_en1); end
        tick();
        n_tests++; if (wr_en0 !== 1'b0) begin n_fail++; $display("FAIL single_after_en0 got %b exp 0", wr_en0); end
        n_tests++; if (dut.rr_ptr_q !== 2'd1) begin n_fail++; $display("FAIL single_rr got %0d exp 1", dut.rr_ptr_q); end
    endtask

    task automatic test_rr_all();
        do_reset();
        offer(WB_ALU0, 5'd3, 32'hA, ALU_MASTER);
        offer(WB_ALU1, 5'd4, 32'hB, ALU_MASTER);
        offer(WB_LS,   5'd6, 32'hC, LOAD_STORE);
        tick(); idle(); #1;
        n_tests++; if ({wr_en0, wr_addr0, wr_data0, wr_tag0} !== {1'b1, 5'd3, 32'hA, 3'd1}) begin n_fail++; $display("FAIL rr_c1_port0 got %h exp %h", {wr_en0, wr_addr0, wr_data0, wr_tag0}, {1'b1, 5'd3, 32'hA, 3'd1}); end
        n_tests++; if ({wr_en1, wr_addr1, wr_data1, wr_tag1} !== {1'b1, 5'd4, 32'hB, 3'd1}) begin n_fail++; $display("FAIL rr_c1_port1 got %h exp %h", {wr_en1, wr_addr1, wr_data1, wr_tag1}, {1'b1, 5'd4, 32'hB, 3'd1}); end
        n_tests++; if (dut.rr_ptr_q !== 2'd0) begin n_fail++; $display("FAIL rr_c1_ptr got %0d exp 0", dut.rr_ptr_q); end
        tick();
        n_tests++; if ({wr_en0, wr_addr0, wr_data0, wr_tag0} !== {1'b1, 5'd6, 32'hC, 3'd2}) begin n_fail++; $display("FAIL rr_c2_port0 got %h exp %h", {wr_en0, wr_addr0, wr_data0, wr_tag0}, {1'b1, 5'd6, 32'hC, 3'd2}); end
        n_tests++; if (wr_en1 !== 1'b0) begin n_fail++; $display("FAIL rr_c2_en1 got %b exp 0", wr_en1); end
        n_tests++; if (dut.rr_ptr_q !== 2'd2) begin n_fail++; $display("FAIL rr_c2_ptr got %0d exp 2", dut.rr_ptr_q); end
        tick();
        n_tests++; if ({wr_en0, wr_en1} !== 2'b00) begin n_fail++; $display("FAIL rr_c3_en got %b exp 00", {wr_en0, wr_en1}); end
        n_tests++; if (dut.rr_ptr_q !== 2'd0) begin n_fail++; $display("FAIL rr_c3_ptr got %0d exp 0", dut.rr_ptr_q); end
    endtask

    task automatic test_collision();
        do_reset();
        offer(WB_ALU0, 5'd7, 32'h70, ALU_MASTER);
        offer(WB_LS,   5'd7, 32'h72, LOAD_STORE);
        tick(); idle(); #1;
        n_tests++; if ({wr_en0, wr_addr0, wr_data0, wr_tag0} !== {1'b1, 5'd7, 32'h70, 3'd1}) begin n_fail++; $display("FAIL coll_c1_port0 got %h exp %h", {wr_en0, wr_addr0, wr_data0, wr_tag0}, {1'b1, 5'd7, 32'h70, 3'd1}); end
        n_tests++; if (wr_en1 !== 1'b0) begin n_fail++; $display("FAIL coll_c1_en1 got %b exp 0", wr_en1); end
        n_tests++; if (in_ready !== 3'b011) begin n_fail++; $display("FAIL coll_c1_ready got %b exp 011", in_ready); end
        tick();
        n_tests++; if ({wr_en0, wr_addr0, wr_data0, wr_tag0} !== {1'b1, 5'd7, 32'h72, 3'd2}) begin n_fail++; $display("FAIL coll_c2_port0 got %h exp %h", {wr_en0, wr_addr0, wr_data0, wr_tag0}, {1'b1, 5'd7, 32'h72, 3'd2}); end
        n_tests++; if (wr_en1 !== 1'b0) begin n_fail++; $display("FAIL coll_c2_en1 got %b exp 0", wr_en1); end
        tick();
        n_tests++; if ({wr_en0, wr_en1} !== 2'b00) begin n_fail++; $display("FAIL coll_c3_en got %b exp 00", {wr_en0, wr_en1}); end
    endtask

    task automatic test_x0();
        do_reset();
        offer(WB_LS, 5'd0, 32'hFF, LOAD_STORE);
        tick(); idle(); #1;
        n_tests++; if ({wr_en0, wr_en1} !== 2'b00) begin n_fail++; $display("FAIL x0_en got %b exp 00", {wr_en0, wr_en1}); end
        n_tests++; if (in_ready !== 3'b111) begin n_fail++; $display("FAIL x0_ready got %b exp 111", in_ready); end
        tick();
        n_tests++; if (dut.slot_valid !== 3'b000) begin n_fail++; $display("FAIL x0_slot got %b exp 000", dut.slot_valid); end
        offer(WB_ALU0, 5'd0, 32'h1,  ALU_MASTER);
        offer(WB_ALU1, 5'd0, 32'h2,  ALU_MASTER);
        offer(WB_LS,   5'd9, 32'h99, LOAD_STORE);
        tick(); idle(); #1;
        n_tests++; if ({wr_en0, wr_addr0, wr_data0, wr_tag0} !== {1'b1, 5'd9, 32'h99, 3'd2}) begin n_fail++; $display("FAIL x0mix_port0 got %h exp %h", {wr_en0, wr_addr0, wr_data0, wr_tag0}, {1'b1, 5'd9, 32'h99, 3'd2}); end
        n_tests++; if (wr_en1 !== 1'b0) begin n_fail++; $display("FAIL x0mix_en1 got %b exp 0", wr_en1); end
        n_tests++; if (in_ready !== 3'b111) begin n_fail++; $display("FAIL x0mix_ready got %b exp 111", in_ready); end
        tick();
        n_tests++; if (dut.slot_valid !== 3'b000) begin n_fail++; $display("FAIL x0mix_slot got %b exp 000", dut.slot_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        offer(WB_ALU0, 5'd1, 32'hA1, ALU_MASTER);
        tick();
        offer(WB_ALU0, 5'd2, 32'hA2, ALU_MASTER);
        #1;
        n_tests++; if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b exp 1", in_ready[0]); end
        n_tests++; if ({wr_en0, wr_addr0, wr_data0, wr_tag0} !== {1'b1, 5'd1, 32'hA1, 3'd1}) begin n_fail++; $display("FAIL b2b_c1_port0 got %h exp %h", {wr_en0, wr_addr0, wr_data0, wr_tag0}, {1'b1, 5'd1, 32'hA1, 3'd1}); end
        tick(); idle(); #1;
        n_tests++; if ({wr_en0, wr_addr0, wr_data0, wr_tag0} !== {1'b1, 5'd2, 32'hA2, 3'd1}) begin n_fail++; $display("FAIL b2b_c2_port0 got %h exp %h", {wr_en0, wr_addr0, wr_data0, wr_tag0}, {1'b1, 5'd2, 32'hA2, 3'd1}); end
        tick();
        n_tests++; if (wr_en0 !== 1'b0) begin n_fail++; $display("FAIL b2b_c3_en0 got %b exp 0", wr_en0); end
    endtask

    task automatic test_stall_flush();
        do_reset();
        offer(WB_ALU0, 5'd10, 32'h100, ALU_MASTER);
        offer(WB_ALU1, 5'd11, 32'h110, ALU_MASTER);
        offer(WB_LS,   5'd12, 32'h120, LOAD_STORE);
        tick(); idle(); rdy = 1'b0; #1;
        n_tests++; if ({wr_en0, wr_en1} !== 2'b00) begin n_fail++; $display("FAIL stall_en got %b exp 00", {wr_en0, wr_en1}); end
        n_tests++; if (in_ready !== 3'b000) begin n_fail++; $display("FAIL stall_ready got %b exp 000", in_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++; if ({wr_en0, wr_en1} !== 2'b00) begin n_fail++; $display("FAIL stall_c%0d_en got %b exp 00", c, {wr_en0, wr_en1}); end
            n_tests++; if (dut.slot_valid !== 3'b111) begin n_fail++; $display("FAIL stall_c%0d_slot got %b exp 111", c, dut.slot_valid); end
        end
        rdy = 1'b1; flush = 1'b1;
        offer(WB_ALU0, 5'd13, 32'h130, ALU_MASTER);
        #1;
        n_tests++; if ({wr_en0, wr_en1} !== 2'b00) begin n_fail++; $display("FAIL flush_en got %b exp 00", {wr_en0, wr_en1}); end
        n_tests++; if (in_ready !== 3'b000) begin n_fail++; $display("FAIL flush_ready got %b exp 000", in_ready); end
        tick(); flush = 1'b0; idle(); #1;
        n_tests++; if (in_ready !== 3'b111) begin n_fail++; $display("FAIL postflush_ready got %b exp 111", in_ready); end
        n_tests++; if (dut.slot_valid !== 3'b000) begin n_fail++; $display("FAIL postflush_slot got %b exp 000", dut.slot_valid); end
        n_tests++; if ({wr_en0, wr_en1} !== 2'b00) begin n_fail++; $display("FAIL postflush_en got %b exp 00", {wr_en0, wr_en1}); end
        tick();
        n_tests++; if ({wr_en0, wr_en1} !== 2'b00) begin n_fail++; $display("FAIL postflush2_en got %b exp 00", {wr_en0, wr_en1}); end
    endtask

    task automatic test_async_rst();
        do_reset();
        offer(WB_ALU0, 5'd14, 32'h140, ALU_MASTER);
        offer(WB_ALU1, 5'd15, 32'h150, ALU_MASTER);
        tick(); idle(); #1;
        n_tests++; if ({wr_en0, wr_en1} !== 2'b11) begin n_fail++; $display("FAIL arst_pre_en got %b exp 11", {wr_en0, wr_en1}); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if ({wr_en0, wr_addr0, wr_data0, wr_tag0, wr_en1, wr_addr1, wr_data1, wr_tag1} !== '0) begin n_fail++; $display("FAIL arst_outputs got %h exp 0", {wr_en0, wr_addr0, wr_data0, wr_tag0, wr_en1, wr_addr1, wr_data1, wr_tag1}); end
        n_tests++; if (dut.slot_valid !== 3'b000) begin n_fail++; $display("FAIL arst_slot got %b exp 000", dut.slot_valid); end
        tick(); rst = 1'b0;
        tick();
        n_tests++; if ({wr_en0, wr_en1} !== 2'b00) begin n_fail++; $display("FAIL arst_post_en got %b exp 00", {wr_en0, wr_en1}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_all();
        test_collision();
        test_x0();
        test_back_to_back();
        test_stall_flush();
        test_async_rst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
